key_encoder_8: RTL and testbench



---
 rtl/key_pkg.sv | 14 +
 rtl/prio_enc_8.sv | 19 +
 rtl/key_encoder_8.sv | 116 +++++++++++
 tb/tb_key_encoder_8.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared widths and FSM state encodings for the front-panel key encoder.
package key_pkg;

  localparam int KEY_W  = 8;
  localparam int CODE_W = 3;

  // Encoding 2'd3 is never produced; the FSM decodes it as IDLE.
  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_REPORT       = 2'd1,
    ST_WAIT_RELEASE = 2'd2
  } state_t;

endpackage

// File: rtl/prio_enc_8.sv
// Combinational 8-to-3 priority encoder: highest set bit wins, zero input gives code 0.
module prio_enc_8
  import key_pkg::*;
(
  input  logic [KEY_W-1:0]  i_stable,
  output logic [CODE_W-1:0] o_code,
  output logic              o_any
);

  always_comb begin
    o_code = '0;
    for (int i = 0; i < KEY_W; i++) begin
      if (i_stable[i]) o_code = CODE_W'(i);
    end
  end

  assign o_any = |i_stable;

endmodule

// File: rtl/key_encoder_8.sv
// Key encoder: 2-flop sync, debounce, priority encode, one report per press via valid/ack.
// Handshake: valid rises with code frozen and stays high until ack is sampled high with
// valid=1; ack while valid=0 is ignored, and enable=0 overrides everything.
module key_encoder_8
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [KEY_W-1:0]  keys,
  input  logic              enable,
  input  logic              ack,
  output logic [CODE_W-1:0] code,
  output logic              valid,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic [KEY_W-1:0]  r_sync1;
  logic [KEY_W-1:0]  r_sync2;
  logic [CNT_W-1:0]  r_cnt;
  logic [KEY_W-1:0]  r_stable;
  state_t            r_state;
  logic [CODE_W-1:0] r_code;
  logic              r_valid;

  logic              w_change;
  logic [CNT_W-1:0]  w_cnt_next;
  logic [CODE_W-1:0] w_enc_code;
  logic              w_any;
  state_t            w_state_next;
  logic [CODE_W-1:0] w_code_next;
  logic              w_valid_next;

  // sync1 != sync2 means sync2 is about to change on this edge.
  assign w_change = (r_sync1 != r_sync2);

  always_comb begin
    w_cnt_next = r_cnt;
    if (w_change)            w_cnt_next = '0;
    else if (r_cnt != CNT_MAX) w_cnt_next = r_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_cnt    <= '0;
      r_stable <= '0;
    end else begin
      r_sync1 <= keys;
      r_sync2 <= r_sync1;
      r_cnt   <= w_cnt_next;
      if (w_cnt_next == CNT_MAX) r_stable <= r_sync2;
    end
  end

  prio_enc_8 u_prio_enc (
    .i_stable (r_stable),
    .o_code   (w_enc_code),
    .o_any    (w_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_code  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_code  <= w_code_next;
      r_valid <= w_valid_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_code_next  = r_code;
    w_valid_next = r_valid;
    if (!enable) begin
      w_state_next = ST_IDLE;
      w_code_next  = '0;
      w_valid_next = 1'b0;
    end else begin
      case (r_state)
        ST_REPORT: begin
          if (ack) begin
            w_valid_next = 1'b0;
            w_state_next = ST_WAIT_RELEASE;
          end
        end
        ST_WAIT_RELEASE: begin
          if (!w_any) w_state_next = ST_IDLE;
        end
        default: begin
          w_state_next = ST_IDLE;
          if (w_any) begin
            w_state_next = ST_REPORT;
            w_code_next  = w_enc_code;
            w_valid_next = 1'b1;
          end
        end
      endcase
    end
  end

  assign code      = r_code;
  assign valid     = r_valid;
  assign busy      = (r_state == ST_REPORT) || (r_state == ST_WAIT_RELEASE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_key_encoder_8.sv
// Bench for key_encoder_8: vector table of single presses plus hand sequences for corner cases.
module tb_key_encoder_8;

  logic       clk;
  logic       rst_n;
  logic [7:0] keys;
  logic       enable;
  logic       ack;
  logic [2:0] code;
  logic       valid;
  logic       busy;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  logic [2:0] exp_q[$];

  typedef struct {
    logic [7:0] k;
    logic [2:0] code;
  } vec_t;

  vec_t vecs[7];

  key_encoder_8 #(.DEBOUNCE_CYCLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .keys      (keys),
    .enable    (enable),
    .ack       (ack),
    .code      (code),
    .valid     (valid),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: act=%0d exp=%0d", name, act, exp);
  endtask

  // Waits for valid, checks latency (if exp_lat >= 0) and pops the expected code.
  task automatic wait_valid(input string name, input int exp_lat);
    int n;
    logic [2:0] e;
    n = 0;
    while (!valid && n < 60) begin
      tick();
      n++;
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 3'd0;
    if (!valid) begin
      check({name, "_timeout"}, 0, 1);
    end else begin
      if (exp_lat >= 0) check({name, "_lat"}, n, exp_lat);
      check({name, "_code"}, int'(code), int'(e));
    end
  endtask

  task automatic press(input string name, input logic [7:0] k, input logic [2:0] e,
                       input int exp_lat);
    exp_q.push_back(e);
    keys = k;
    wait_valid(name, exp_lat);
  endtask

  task automatic ack_cycle(input string name);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check({name, "_ack_valid"}, int'(valid), 0);
    check({name, "_ack_busy"}, int'(busy), 1);
  endtask

  task automatic release_wait(input string name);
    int n;
    keys = 8'h00;
    n = 0;
    while (busy && n < 30) begin
      tick();
      n++;
    end
    check({name, "_idle_busy"}, int'(busy), 0);
    check({name, "_idle_state"}, int'(dbg_state), 0);
  endtask

  initial begin
    logic seen;
    vecs[0] = '{8'h08, 3'd3};
    vecs[1] = '{8'h81, 3'd7};
    vecs[2] = '{8'h24, 3'd5};
    vecs[3] = '{8'h01, 3'd0};
    vecs[4] = '{8'h40, 3'd6};
    vecs[5] = '{8'hFF, 3'd7};
    vecs[6] = '{8'h10, 3'd4};

    rst_n  = 1'b0;
    keys   = 8'h00;
    enable = 1'b0;
    ack    = 1'b0;
    repeat (3) tick();
    check("rst_code", int'(code), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_state", int'(dbg_state), 0);
    rst_n  = 1'b1;
    enable = 1'b1;
    repeat (8) tick();

    // ack with nothing pending is ignored
    ack = 1'b1;
    repeat (3) tick();
    ack = 1'b0;
    check("stray_ack_valid", int'(valid), 0);
    check("stray_ack_state", int'(dbg_state), 0);

    foreach (vecs[i]) begin
      press($sformatf("vec%0d", i), vecs[i].k, vecs[i].code, 7);
      ack_cycle($sformatf("vec%0d", i));
      release_wait($sformatf("vec%0d", i));
    end

    // extra key during WAIT_RELEASE gives no second report
    press("multi", 8'h81, 3'd7, 7);
    ack_cycle("multi");
    keys = 8'h85;
    seen = 1'b0;
    repeat (20) begin
      tick();
      if (valid) seen = 1'b1;
    end
    check("multi_no_rereport", int'(seen), 0);
    check("multi_still_busy", int'(busy), 1);
    release_wait("multi");

    // bounce shorter than the debounce window
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      keys = (i % 2 == 0) ? 8'h01 : 8'h00;
      repeat (2) begin
        tick();
        if (valid) seen = 1'b1;
      end
    end
    check("bounce_no_valid", int'(seen), 0);
    press("bounce_hold", 8'h01, 3'd0, 7);
    ack_cycle("bounce_hold");
    release_wait("bounce_hold");

    // release before ack: report stays pending
    press("hold", 8'h20, 3'd5, 7);
    keys = 8'h00;
    repeat (15) tick();
    check("hold_valid", int'(valid), 1);
    check("hold_code", int'(code), 5);
    check("hold_state", int'(dbg_state), 1);
    ack_cycle("hold");
    tick();
    check("hold_idle_busy", int'(busy), 0);

    // enable drop clears the report; re-enable re-reports from stable
    press("en", 8'h40, 3'd6, 7);
    enable = 1'b0;
    tick();
    check("en_off_valid", int'(valid), 0);
    check("en_off_code", int'(code), 0);
    check("en_off_busy", int'(busy), 0);
    enable = 1'b1;
    exp_q.push_back(3'd6);
    wait_valid("en_back", 1);
    ack_cycle("en_back");
    release_wait("en_back");

    // ack and enable=0 together: enable wins, FSM lands in IDLE
    press("ackdis", 8'h08, 3'd3, 7);
    ack    = 1'b1;
    enable = 1'b0;
    tick();
    ack = 1'b0;
    check("ackdis_state", int'(dbg_state), 0);
    check("ackdis_valid", int'(valid), 0);
    enable = 1'b1;
    exp_q.push_back(3'd3);
    wait_valid("ackdis_back", 1);
    ack_cycle("ackdis_back");
    release_wait("ackdis_back");

    // asynchronous reset in REPORT
    press("arst", 8'h08, 3'd3, 7);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_valid", int'(valid), 0);
    check("arst_code", int'(code), 0);
    check("arst_busy", int'(busy), 0);
    tick();
    tick();
    rst_n = 1'b1;
    exp_q.push_back(3'd3);
    wait_valid("arst_rerep", 7);
    ack_cycle("arst_rerep");
    release_wait("arst_rerep");

    check("scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
